// File: rtl/hms_alarm_clock.sv
// Purpose: h:m:s clock with NUM_ALARM alarm channels, SETUP/ALARM edit modes and display mux (HMS_HOUR_EN builds in the hour field).
// Latency: time, alarm and flag registers update on the edge after a tick or pulse; o_alarm and o_tick are combinational.
// Backpressure: none; every input pulse is consumed in the cycle it is presented.
module hms_alarm_clock #(
  parameter int TICK_DIV  = 50000000,
  parameter int NUM_ALARM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mode_pls,
  input  logic                 i_pos_pls,
  input  logic                 i_inc_pls,
  input  logic                 i_sel_pls,
  input  logic                 i_en_pls,
  input  logic                 i_ack_pls,
  output logic [5:0]           o_sec,
  output logic [5:0]           o_min,
  output logic [4:0]           o_hour,
  output logic [5:0]           o_disp_sec,
  output logic [5:0]           o_disp_min,
  output logic [4:0]           o_disp_hour,
  output logic [1:0]           o_mode,
  output logic [1:0]           o_pos,
  output logic [2:0]           o_alarm_idx,
  output logic [NUM_ALARM-1:0] o_alarm_en,
  output logic [NUM_ALARM-1:0] o_alarm_hit,
  output logic                 o_alarm,
  output logic                 o_tick
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int            IW       = (NUM_ALARM > 1) ? $clog2(NUM_ALARM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_ALARM - 1);

  typedef enum logic [1:0] {MODE_CLOCK = 2'd0, MODE_SETUP = 2'd1, MODE_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_t;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

`ifdef HMS_HOUR_EN
  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction
`endif

  mode_t                mode_q, mode_d;
  pos_t                 pos_q, pos_d;
  logic [CW-1:0]        cnt_q;
  logic                 tick;
  logic [5:0]           sec_q, min_q;
  logic [2:0]           idx_q;
  logic [IW-1:0]        sel;
  logic [5:0]           al_sec [NUM_ALARM];
  logic [5:0]           al_min [NUM_ALARM];
`ifdef HMS_HOUR_EN
  logic [4:0]           hour_q;
  logic [4:0]           al_hour [NUM_ALARM];
`endif
  logic [NUM_ALARM-1:0] en_q, hit_q, match_q, match_now, sel_mask, dis_mask, rise;

  assign sel      = idx_q[IW-1:0];
  assign sel_mask = NUM_ALARM'(1) << idx_q;

  // Mode and edit-position state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CLOCK;
      pos_q  <= POS_SEC;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // Next mode/position; a mode change always returns the cursor to seconds.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (i_mode_pls) begin
      pos_d = POS_SEC;
      case (mode_q)
        MODE_CLOCK: mode_d = MODE_SETUP;
        MODE_SETUP: mode_d = MODE_ALARM;
        default:    mode_d = MODE_CLOCK;
      endcase
    end else if (i_pos_pls) begin
      case (pos_q)
        POS_SEC:  pos_d = POS_MIN;
`ifdef HMS_HOUR_EN
        POS_MIN:  pos_d = POS_HOUR;
`endif
        default:  pos_d = POS_SEC;
      endcase
    end
  end

  assign tick = (mode_q != MODE_SETUP) && (cnt_q == CNT_LAST);

  // Prescaler: free-runs outside SETUP, parked at zero while the live time is edited.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (mode_q == MODE_SETUP || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Live time: ticks ripple carries upward; SETUP edits bump one field without carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q  <= '0;
      min_q  <= '0;
`ifdef HMS_HOUR_EN
      hour_q <= '0;
`endif
    end else if (tick) begin
      sec_q <= inc60(sec_q);
      if (sec_q == 6'd59) begin
        min_q <= inc60(min_q);
`ifdef HMS_HOUR_EN
        if (min_q == 6'd59) hour_q <= inc24(hour_q);
`endif
      end
    end else if (mode_q == MODE_SETUP && i_inc_pls) begin
      case (pos_q)
        POS_SEC:  sec_q  <= inc60(sec_q);
        POS_MIN:  min_q  <= inc60(min_q);
`ifdef HMS_HOUR_EN
        POS_HOUR: hour_q <= inc24(hour_q);
`endif
        default:  ;
      endcase
    end
  end

  // Alarm times: the selected channel is edited field by field in ALARM mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ALARM; k++) begin
        al_sec[k]  <= '0;
        al_min[k]  <= '0;
`ifdef HMS_HOUR_EN
        al_hour[k] <= '0;
`endif
      end
    end else if (mode_q == MODE_ALARM && i_inc_pls) begin
      case (pos_q)
        POS_SEC:  al_sec[sel]  <= inc60(al_sec[sel]);
        POS_MIN:  al_min[sel]  <= inc60(al_min[sel]);
`ifdef HMS_HOUR_EN
        POS_HOUR: al_hour[sel] <= inc24(al_hour[sel]);
`endif
        default:  ;
      endcase
    end
  end

  // Selected alarm channel wraps at NUM_ALARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (i_sel_pls) begin
      idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Compare live time against every enabled alarm channel.
  always_comb begin
    match_now = '0;
    for (int k = 0; k < NUM_ALARM; k++) begin
      match_now[k] = en_q[k] && (sec_q == al_sec[k]) && (min_q == al_min[k])
`ifdef HMS_HOUR_EN
                     && (hour_q == al_hour[k])
`endif
                     ;
    end
  end

  assign rise     = match_now & ~match_q;
  assign dis_mask = i_en_pls ? (en_q & sel_mask) : '0;

  // Enables, match history and sticky hits: a new match beats ack, disabling beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      hit_q   <= '0;
      match_q <= '0;
    end else begin
      match_q <= match_now;
      if (i_en_pls) en_q <= en_q ^ sel_mask;
      hit_q   <= ((i_ack_pls ? '0 : hit_q) | rise) & ~dis_mask;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_disp_sec = (mode_q == MODE_ALARM) ? al_sec[sel] : sec_q;
  assign o_disp_min = (mode_q == MODE_ALARM) ? al_min[sel] : min_q;
`ifdef HMS_HOUR_EN
  assign o_hour      = hour_q;
  assign o_disp_hour = (mode_q == MODE_ALARM) ? al_hour[sel] : hour_q;
`else
  assign o_hour      = '0;
  assign o_disp_hour = '0;
`endif
  assign o_mode      = mode_q;
  assign o_pos       = pos_q;
  assign o_alarm_idx = idx_q;
  assign o_alarm_en  = en_q;
  assign o_alarm_hit = hit_q;
  assign o_alarm     = |hit_q;
  assign o_tick      = tick;

endmodule

// File: tb/tb_hms_alarm_clock.sv
// Purpose: randomized and directed stimulus for hms_alarm_clock against a seconds-of-day reference model.
// Latency: model advances once per clk edge; DUT outputs are compared on the falling edge.
// Backpressure: none; stimulus is one pulse vector per cycle.
module tb_hms_alarm_clock;

  localparam int TD = 4;
  localparam int NA = 4;
`ifdef HMS_HOUR_EN
  localparam int DAY  = 86400;
  localparam int NPOS = 3;
`else
  localparam int DAY  = 3600;
  localparam int NPOS = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_mode_pls = 1'b0, i_pos_pls = 1'b0, i_inc_pls = 1'b0;
  logic          i_sel_pls = 1'b0, i_en_pls = 1'b0, i_ack_pls = 1'b0;
  logic [5:0]    o_sec, o_min, o_disp_sec, o_disp_min;
  logic [4:0]    o_hour, o_disp_hour;
  logic [1:0]    o_mode, o_pos;
  logic [2:0]    o_alarm_idx;
  logic [NA-1:0] o_alarm_en, o_alarm_hit;
  logic          o_alarm, o_tick;

  always #5 clk = ~clk;

  hms_alarm_clock #(.TICK_DIV(TD), .NUM_ALARM(NA)) dut (
    .clk(clk), .rst(rst),
    .i_mode_pls(i_mode_pls), .i_pos_pls(i_pos_pls), .i_inc_pls(i_inc_pls),
    .i_sel_pls(i_sel_pls), .i_en_pls(i_en_pls), .i_ack_pls(i_ack_pls),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_disp_sec(o_disp_sec), .o_disp_min(o_disp_min), .o_disp_hour(o_disp_hour),
    .o_mode(o_mode), .o_pos(o_pos), .o_alarm_idx(o_alarm_idx),
    .o_alarm_en(o_alarm_en), .o_alarm_hit(o_alarm_hit),
    .o_alarm(o_alarm), .o_tick(o_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: time kept as seconds of the day, alarms likewise.
  int m_t, m_cnt, m_mode, m_pos, m_idx;
  int a_t [NA];
  bit m_en [NA];
  bit m_hit [NA];
  bit m_prev [NA];

  function automatic int fld(input int t, input int f);
    case (f)
      0:       return t % 60;
      1:       return (t / 60) % 60;
      default: return t / 3600;
    endcase
  endfunction

  function automatic int bump(input int t, input int f);
    case (f)
      0:       return t - fld(t, 0) + (fld(t, 0) + 1) % 60;
      1:       return t - fld(t, 1) * 60 + ((fld(t, 1) + 1) % 60) * 60;
      default: return t - fld(t, 2) * 3600 + ((fld(t, 2) + 1) % 24) * 3600;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit mp, input bit pp, input bit ip,
                            input bit sp, input bit ep, input bit ap);
    bit tk;
    bit mt;
    if (r) begin
      m_t = 0; m_cnt = 0; m_mode = 0; m_pos = 0; m_idx = 0;
      for (int k = 0; k < NA; k++) begin
        a_t[k] = 0; m_en[k] = 0; m_hit[k] = 0; m_prev[k] = 0;
      end
      return;
    end
    tk = (m_mode != 1) && (m_cnt == TD - 1);
    for (int k = 0; k < NA; k++) begin
      mt = m_en[k] && (a_t[k] == m_t);
      if (ap) m_hit[k] = 0;
      if (mt && !m_prev[k]) m_hit[k] = 1;
      m_prev[k] = mt;
    end
    if (ep) begin
      if (m_en[m_idx]) begin
        m_en[m_idx]  = 0;
        m_hit[m_idx] = 0;
      end else begin
        m_en[m_idx] = 1;
      end
    end
    if (tk) m_t = (m_t + 1) % DAY;
    else if (m_mode == 1 && ip) m_t = bump(m_t, m_pos);
    if (m_mode == 2 && ip) a_t[m_idx] = bump(a_t[m_idx], m_pos);
    m_cnt = (m_mode == 1 || tk) ? 0 : m_cnt + 1;
    if (sp) m_idx = (m_idx + 1) % NA;
    if (mp) begin
      m_pos  = 0;
      m_mode = (m_mode + 1) % 3;
    end else if (pp) begin
      m_pos = (m_pos + 1) % NPOS;
    end
  endtask

  task automatic compare_all();
    int en_v, hit_v, d;
    en_v = 0; hit_v = 0;
    for (int k = 0; k < NA; k++) begin
      en_v  |= int'(m_en[k]) << k;
      hit_v |= int'(m_hit[k]) << k;
    end
    d = (m_mode == 2) ? a_t[m_idx] : m_t;
    chk("sec", o_sec, fld(m_t, 0));
    chk("min", o_min, fld(m_t, 1));
    chk("hour", o_hour, fld(m_t, 2));
    chk("disp_sec", o_disp_sec, fld(d, 0));
    chk("disp_min", o_disp_min, fld(d, 1));
    chk("disp_hour", o_disp_hour, fld(d, 2));
    chk("mode", o_mode, m_mode);
    chk("pos", o_pos, m_pos);
    chk("idx", o_alarm_idx, m_idx);
    chk("en", o_alarm_en, en_v);
    chk("hit", o_alarm_hit, hit_v);
    chk("alarm", o_alarm, (hit_v != 0) ? 1 : 0);
    chk("tick", o_tick, (m_mode != 1 && m_cnt == TD - 1) ? 1 : 0);
  endtask

  // One clock cycle: drive a pulse vector, advance the model, compare on the falling edge.
  task automatic step(input bit r, input bit mp, input bit pp, input bit ip,
                      input bit sp, input bit ep, input bit ap);
    rst = r; i_mode_pls = mp; i_pos_pls = pp; i_inc_pls = ip;
    i_sel_pls = sp; i_en_pls = ep; i_ack_pls = ap;
    model_step(r, mp, pp, ip, sp, ep, ap);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_mode(input int md);
    for (int i = 0; i < 3 && m_mode != md; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("goto_mode", o_mode, md);
  endtask

  // Walk the cursor SEC..HOUR, bumping each field to its target (live in SETUP, alarm in ALARM).
  task automatic edit_fields(input int h, input int m, input int s);
    int tgt [3];
    int cur, modv, n;
    tgt = '{s, m, h};
    for (int f = 0; f < NPOS; f++) begin
      cur  = fld((m_mode == 2) ? a_t[m_idx] : m_t, f);
      modv = (f == 2) ? 24 : 60;
      n    = (tgt[f] - cur + modv) % modv;
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);

    // Tick cadence straight out of reset.
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("tick_cycle%0d", c), o_tick, (c % TD == 0) ? 1 : 0);
      idle();
    end
    chk("sec_after_8", o_sec, 2);

    // Rollover from the last second of the day (hour) or hour (no hour field).
    goto_mode(1);
    edit_fields(23, 59, 59);
    goto_mode(0);
    for (int i = 0; i < 2 * TD && !(m_mode != 1 && m_cnt == TD - 1); i++) idle();
    chk("pre_wrap_sec", o_sec, 59);
    chk("pre_wrap_min", o_min, 59);
    idle();
    chk("wrap_sec", o_sec, 0);
    chk("wrap_min", o_min, 0);
    chk("wrap_hour", o_hour, 0);

    // Alarm 1 at 00:00:03 with time running from zero.
    step(1, 0, 0, 0, 0, 0, 0);
    goto_mode(1);
    step(0, 0, 0, 0, 1, 0, 0);
    goto_mode(2);
    edit_fields(0, 0, 3);
    step(0, 0, 0, 0, 0, 1, 0);
    goto_mode(0);
    for (int i = 0; i < 8 * TD && m_t != 3; i++) idle();
    chk("alarm_sec3", o_sec, 3);
    chk("hit_before", o_alarm_hit, 0);
    idle();
    chk("hit_ch1", o_alarm_hit, 2);
    chk("alarm_out", o_alarm, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ack_clears", o_alarm_hit, 0);
    chk("alarm_off", o_alarm, 0);
    idle();
    chk("no_reset_on_hold", o_alarm_hit, 0);
    chk("still_sec3", o_sec, 3);

    // SETUP seconds increment wraps without carry; prescaler held.
    goto_mode(1);
    edit_fields(0, 7, 59);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("setup_sec_wrap", o_sec, 0);
    chk("setup_min_kept", o_min, 7);
    repeat (100) idle();
    chk("setup_hold_sec", o_sec, 0);
    chk("setup_hold_tick", o_tick, 0);

    // Rising match and ack in the same cycle: set wins.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("set_beats_ack", o_alarm_hit, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ack_after_set", o_alarm_hit, 0);

    // Reset mid-count clears everything; counting restarts TICK_DIV cycles later.
    repeat (6) idle();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_sec", o_sec, 0);
    chk("rst_en", o_alarm_en, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_mode", o_mode, 0);
    repeat (TD - 1) idle();
    chk("resume_before", o_sec, 0);
    idle();
    chk("resume_after", o_sec, 1);

    // Random pulse mix; alarms start at zero so enables and small edits produce matches.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(499) == 0, $urandom_range(39) == 0, $urandom_range(19) == 0,
           $urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
           $urandom_range(23) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
